id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly downstream of the register file. Latches both read
//  operands (outData1/outData2), immediate, control and destination tag of the decoded
//  instruction. Resolves RAW hazards: EX-stage operand forwarding from EX/MEM and MEM/WB.
//  Drives a load-use stall back to PC/IF/ID.
// PARAMETERS
//  CTRL_W  8   width of opaque EX/MEM/WB control bundle, passed through unchanged
// PORTS
//  CLK            in   1       clock; all state updates on posedge
//  RST            in   1       synchronous, active-high reset
//  id_valid       in   1       ID holds a real instruction
//  id_src1        in   4       register tag of operand 1 (matches R1/readSpecReg)
//  id_src2        in   4       register tag of operand 2 (general only)
//  id_data1       in   16      register-file outData1
//  id_data2       in   16      register-file outData2
//  id_imm         in   16      sign/zero-extended immediate
//  id_ctrl        in   CTRL_W  control bundle
//  id_dst         in   4       destination tag
//  id_reg_write   in   1       instruction writes a register
//  id_mem_read    in   1       instruction is a load
//  flush          in   1       branch taken: squash the ID instruction
//  mem_dst        in   4       EX/MEM destination tag
//  mem_reg_write  in   1       EX/MEM writes a register
//  mem_result     in   16      EX/MEM ALU result
//  wb_dst         in   4       MEM/WB destination tag
//  wb_reg_write   in   1       MEM/WB writes a register
//  wb_result      in   16      MEM/WB write-back data
//  ex_valid       out  1       EX holds a real instruction
//  ex_op1/ex_op2  out  16      forwarded operands to ALU (combinational from regs + bypass)
//  ex_imm         out  16      latched immediate
//  ex_ctrl        out  CTRL_W  latched control
//  ex_dst         out  4       latched destination tag
//  ex_reg_write   out  1       latched, forced 0 when bubble
//  ex_mem_read    out  1       latched, forced 0 when bubble
//  stall_id       out  1       hold PC and IF/ID this cycle (combinational)
// BEHAVIOUR
//  Tags: 0-7 general R0-R7, 8 SP, 9 IH, 10 T, 15 NONE (no operand/dest). 11-14 unused, never match.
//  Reset: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_dst/src=NONE, data/imm/ctrl=0.
//  Reset: stall_id=0; ex_op* = 0.
//  Latency 1: each posedge, unless bubble, ID fields load into EX regs.
//  Latched data: id_data1/2, id_src1/2 (sources kept for forwarding).
//  Bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0, dst=NONE) loaded when:
//  flush, stall_id, or !id_valid. flush outranks stall; stall with flush -> one bubble.
//  match(t,d,w) = w & (t!=NONE) & (t==d).
//  Load-use: stall_id = id_valid & ex_valid & ex_mem_read & ex_dst!=NONE &
//    (id_src1==ex_dst | id_src2==ex_dst). Stall lasts exactly one cycle per load.
//  Forwarding (EX stage, per operand, latched src s):
//    match(s,mem_dst,mem_reg_write) -> mem_result; else match(s,wb_dst,wb_reg_write) ->
//    wb_result; else latched data. MEM has priority over WB (newer value).
//  Bypass is 16-bit, no arithmetic. WB->ID is covered by regfile negedge write; not bypassed.
//  R0 is an ordinary register (no hard-zero); SP/IH/T forward like any tag.
// CONFIGURATION
//  IDEX_FORWARD_EN defined: forwarding and load-use-only stall as above.
//  IDEX_FORWARD_EN undefined: ex_op* = latched data; stall_id also asserted while any
//    ID source matches the EX instr (ex_valid & ex_reg_write) or the EX/MEM instr
//    (mem_reg_write & mem_dst). Interlock held until the producer reaches WB.
// STRUCTURE
//  Shared include pipe_defs.vh: tag constants (TAG_SP=8, TAG_IH=9, TAG_T=10, TAG_NONE=15),
//  TAG_W=4, default CTRL_W.
//  Sub-module fwd_mux: (src, reg data, mem/wb dst,we,result) -> operand. Two instances.
// TESTING
//  1 RST=1 two cycles -> ex_valid=0, ex_reg_write=0, stall_id=0, ex_dst=15.
//  2 ADD R1<-.. in EX/MEM (mem_result=16'h1234), next uses src1=1, id_data1=0 -> ex_op1=16'h1234.
//  3 mem_dst=wb_dst=3, mem_result=16'hAAAA, wb_result=16'h5555, src2=3 -> ex_op2=16'hAAAA.
//  4 LW R2 in EX, ID src1=2 -> stall_id=1 one cycle, bubble in EX; then ex_op1 via WB.
//  5 flush=1 with stall_id=1 -> next ex_valid=0, ex_reg_write=0; following cycle stall_id=0.
//  6 MTSP: wb_dst=8, wb_result=16'hBF00, src1=8 -> ex_op1=16'hBF00;
//    w/o IDEX_FORWARD_EN stall held 2 cycles.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - register tag encoding, widths and tag-match helper for the ID/EX stage
package id_ex_stage_pkg;

    localparam int TAG_W          = 4;
    localparam int DATA_W         = 16;
    localparam int CTRL_W_DEFAULT = 8;

    // Tags 0-7 are R0-R7; 11-14 are unused encodings.
    typedef enum logic [TAG_W-1:0] {
        TAG_SP   = 4'd8,
        TAG_IH   = 4'd9,
        TAG_T    = 4'd10,
        TAG_NONE = 4'd15
    } tagE;

    // Unused encodings and NONE never produce a match.
    function automatic logic tagMatch(input logic [TAG_W-1:0] t,
                                      input logic [TAG_W-1:0] d,
                                      input logic w);
        return w && (t <= TAG_T) && (t == d);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - per-operand bypass select: EX/MEM, then MEM/WB, else latched data
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [TAG_W-1:0]  src,
    input  logic [DATA_W-1:0] regData,
    input  logic [TAG_W-1:0]  memDst,
    input  logic              memWe,
    input  logic [DATA_W-1:0] memResult,
    input  logic [TAG_W-1:0]  wbDst,
    input  logic              wbWe,
    input  logic [DATA_W-1:0] wbResult,
    output logic [DATA_W-1:0] operand
);

    // MEM holds the younger producer, so it wins over WB.
    always_comb begin
        operand = regData;
        if (tagMatch(src, memDst, memWe)) begin
            operand = memResult;
        end else if (tagMatch(src, wbDst, wbWe)) begin
            operand = wbResult;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with RAW bypass and load-use stall
// IDEX_FORWARD_EN selects bypassing; without it the stage interlocks until the producer reaches WB.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [TAG_W-1:0]  id_src1,
    input  logic [TAG_W-1:0]  id_src2,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [TAG_W-1:0]  id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic [TAG_W-1:0]  mem_dst,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [TAG_W-1:0]  wb_dst,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [TAG_W-1:0]  ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              stall_id
);

    logic [TAG_W-1:0]  exSrc1;
    logic [TAG_W-1:0]  exSrc2;
    logic [DATA_W-1:0] exData1;
    logic [DATA_W-1:0] exData2;
    logic              loadUse;
    logic              stallRaw;
    logic              bubble;

    assign loadUse = id_valid && ex_valid && ex_mem_read && (ex_dst != TAG_NONE) &&
                     ((id_src1 == ex_dst) || (id_src2 == ex_dst));

`ifdef IDEX_FORWARD_EN
    assign stallRaw = loadUse;

    id_ex_stage_fwd_mux uFwd1 (
        .src       (exSrc1),
        .regData   (exData1),
        .memDst    (mem_dst),
        .memWe     (mem_reg_write),
        .memResult (mem_result),
        .wbDst     (wb_dst),
        .wbWe      (wb_reg_write),
        .wbResult  (wb_result),
        .operand   (ex_op1)
    );

    id_ex_stage_fwd_mux uFwd2 (
        .src       (exSrc2),
        .regData   (exData2),
        .memDst    (mem_dst),
        .memWe     (mem_reg_write),
        .memResult (mem_result),
        .wbDst     (wb_dst),
        .wbWe      (wb_reg_write),
        .wbResult  (wb_result),
        .operand   (ex_op2)
    );
`else
    logic exProducer;
    logic unusedNoFwd;

    // Hold ID while a producer sits in EX or MEM; the regfile covers the WB case.
    assign exProducer = ex_valid && ex_reg_write;
    assign stallRaw   = loadUse ||
                        (id_valid && (tagMatch(id_src1, ex_dst,  exProducer)    ||
                                      tagMatch(id_src2, ex_dst,  exProducer)    ||
                                      tagMatch(id_src1, mem_dst, mem_reg_write) ||
                                      tagMatch(id_src2, mem_dst, mem_reg_write)));

    assign ex_op1 = exData1;
    assign ex_op2 = exData2;

    assign unusedNoFwd = ^{exSrc1, exSrc2, mem_result, wb_dst, wb_reg_write, wb_result};
`endif

    assign stall_id = stallRaw && !RST;
    assign bubble   = flush || stall_id || !id_valid;

    // A bubble is loaded with the same values as reset so nothing downstream can match it.
    always_ff @(posedge CLK) begin
        if (RST || bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_dst       <= TAG_NONE;
            exSrc1       <= TAG_NONE;
            exSrc2       <= TAG_NONE;
            exData1      <= '0;
            exData2      <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
        end else begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_dst       <= id_dst;
            exSrc1       <= id_src1;
            exSrc2       <= id_src2;
            exData1      <= id_data1;
            exData2      <= id_data2;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
        end
    end

endmodule
